// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
// Optional MULDIV_FAST_MUL_EN: single-cycle array product for MULT/MULTU (IDLE -> FIN).
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, next_state;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, ua, ub;
    logic               neg_q, neg_r, b_zero;
    logic [2*WIDTH-1:0] p;
    logic [CW-1:0]      cnt;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_upper, shifted, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_mag, mul_res;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Operand conditioning (abs, signs, accumulator clear) happens on the accept edge,
    // so RUN starts in the next cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                next_state = op[1] ? RUN : FIN;
`else
                next_state = RUN;
`endif
            end
            RUN:  if (cnt == '0) next_state = FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        is_signed = ~op[0];
        abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

        // Shift/add: multiplier sits in the low half and drains out to the right.
        mul_upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, ua} : '0);
        mul_next  = {mul_upper, p[WIDTH-1:1]};

        // Restoring divide: remainder high, dividend/quotient low.
        shifted   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff      = shifted - {1'b0, ub};
        div_next  = diff[WIDTH] ? {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],    p[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
        mul_mag   = {{WIDTH{1'b0}}, ua} * {{WIDTH{1'b0}}, ub};
`else
        mul_mag   = p;
`endif
        mul_res   = neg_q ? -mul_mag : mul_mag;
        quo       = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem       = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

        if (!op_q[1]) begin
            fin_hi = mul_res[2*WIDTH-1:WIDTH];
            fin_lo = mul_res[WIDTH-1:0];
        end else if (b_zero) begin
            fin_hi = a_q;
            fin_lo = '1;
        end else begin
            fin_hi = rem;
            fin_lo = quo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            ua     <= '0;
            ub     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            p      <= '0;
            cnt    <= '0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (start) begin
                        op_q   <= op;
                        a_q    <= a;
                        ua     <= abs_a;
                        ub     <= abs_b;
                        neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= is_signed & a[WIDTH-1];
                        b_zero <= (b == '0);
                        p      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt    <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    p   <= op_q[1] ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                end
                FIN: begin
                    hi <= fin_hi;
                    lo <= fin_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);
endmodule
